// File: rtl/cmd_dispatch_sched.sv
// Host command scheduler feeding two NTT engine cores.
// Each core gets its own FIFO plus output register; a halt drains both.
module cmd_dispatch_sched #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] in_cmd,
    output logic        in_ready,
    output logic        cmd_valid_0,
    output logic [7:0]  cmd_opcode_0,
    output logic [3:0]  cmd_slot_0,
    output logic [47:0] cmd_dma_addr_0,
    input  logic        engine_ready_0,
    output logic        cmd_valid_1,
    output logic [7:0]  cmd_opcode_1,
    output logic [3:0]  cmd_slot_1,
    output logic [47:0] cmd_dma_addr_1,
    input  logic        engine_ready_1,
    output logic [CW-1:0] q_count_0,
    output logic [CW-1:0] q_count_1,
    output logic        halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 60;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_e;

    state_e state_q, state_d;

    logic [1:0]           vld_q;
    logic [1:0]           push, pop, fire, eng_rdy;
    logic [1:0][CW-1:0]   cnt_q, cnt_d;
    logic [1:0][AW-1:0]   rd_q, wr_q;
    logic [1:0][EW-1:0]   out_q;
    logic [EW-1:0]        mem_q [2][DEPTH];
    logic [EW-1:0]        entry;
    logic                 xfer_in, is_halt, idle;
    logic                 unused_bits;

    assign eng_rdy     = {engine_ready_1, engine_ready_0};
    assign entry       = {in_cmd[63:52], in_cmd[47:0]};
    assign is_halt     = (in_cmd[63:56] == 8'h00);
    assign unused_bits = ^in_cmd[51:49];

    // A full queue on either core stalls intake for both.
    assign in_ready = (state_q == S_RUN)
                   && (cnt_q[0] < CW'(DEPTH))
                   && (cnt_q[1] < CW'(DEPTH));
    assign xfer_in  = in_valid && in_ready;
    assign idle     = (cnt_q == '0) && (vld_q == '0);

    always_comb begin
        push  = '0;
        pop   = '0;
        fire  = '0;
        cnt_d = cnt_q;
        for (int c = 0; c < 2; c++) begin
            push[c]  = xfer_in && !is_halt && (in_cmd[48] == 1'(c));
            fire[c]  = vld_q[c] && eng_rdy[c];
            pop[c]   = (cnt_q[c] != '0) && (!vld_q[c] || fire[c]);
            cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:    if (xfer_in && is_halt) state_d = S_DRAIN;
            S_DRAIN:  if (idle) state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            vld_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int c = 0; c < 2; c++) begin
                if (push[c]) wr_q[c] <= wr_q[c] + AW'(1);
                if (pop[c]) begin
                    out_q[c] <= mem_q[c][rd_q[c]];
                    vld_q[c] <= 1'b1;
                    rd_q[c]  <= rd_q[c] + AW'(1);
                end else if (fire[c]) begin
                    vld_q[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) mem_q[c][wr_q[c]] <= entry;
        end
    end

    assign cmd_valid_0    = vld_q[0];
    assign cmd_opcode_0   = out_q[0][59:52];
    assign cmd_slot_0     = out_q[0][51:48];
    assign cmd_dma_addr_0 = out_q[0][47:0];
    assign cmd_valid_1    = vld_q[1];
    assign cmd_opcode_1   = out_q[1][59:52];
    assign cmd_slot_1     = out_q[1][51:48];
    assign cmd_dma_addr_1 = out_q[1][47:0];
    assign q_count_0      = cnt_q[0];
    assign q_count_1      = cnt_q[1];
    assign halted         = (state_q == S_HALTED);

endmodule
